wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
// - Round-robin arbiter sharing one Wishbone slave (the 64x32 wb_memory) among NUM_REQ requesters.
// - One transaction per grant. Single-cycle strobe to the slave, then waits for ack with cycle held.
// - Address range check before the slave is touched; ack timeout returns an error to the requester.
// - Sits between CPU/DMA-style masters and the memory. Top level resolves the slave's inout data bus.
// PARAMETERS
// - NUM_REQ     2   number of requesters, 2..4
// - ADDR_LIMIT  64  addresses >= this are rejected with s_err, no slave access
// - TIMEOUT     16  WAIT cycles without m_ack before s_err, >=2
// PORTS
// - clk        in   1          system clock, rising edge
// - rst_n      in   1          asynchronous reset, active low
// - s_cyc      in   NUM_REQ    per-requester cycle
// - s_stb      in   NUM_REQ    per-requester strobe; held until s_ack or s_err
// - s_we       in   NUM_REQ    per-requester write enable
// - s_adr      in   NUM_REQ*32 packed addresses, requester i at [32i+:32]
// - s_dat_w    in   NUM_REQ*32 packed write data
// - s_dat_r    out  32         read data, valid with the s_ack pulse of a read
// - s_ack      out  NUM_REQ    one-cycle completion pulse
// - s_err      out  NUM_REQ    one-cycle error pulse (range or timeout)
// - m_cyc      out  1          to slave cyc
// - m_stb      out  1          to slave stb
// - m_we       out  1          to slave we
// - m_adr      out  32         to slave addr
// - m_dat_w    out  32         write data. Top drives the inout bus with it when m_oe=1.
// - m_oe       out  1          1 while m_cyc & m_we: top-level tristate enable
// - m_dat_r    in   1x32       read data from inout bus
// - m_ack      in   1          slave ack
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, state IDLE, priority pointer 0, timeout counter 0.
// - Reset mid-transaction aborts it immediately. No ack or err is issued for it.
// - Request(i) = s_cyc[i] & s_stb[i]. Sampled only in IDLE.
// - States:
//   - IDLE: if any request, pick the first requester at or after ptr (wrapping) and register it as grant g.
//     - If s_adr[g] >= ADDR_LIMIT, go to ERR; otherwise latch adr/we/dat into m_* and go to ISSUE.
//   - ISSUE (1 cycle): m_cyc=1, m_stb=1, then go to WAIT.
//   - WAIT: m_cyc=1, m_stb=0, count up each cycle.
//     - On m_ack: capture m_dat_r into s_dat_r if read, pulse s_ack[g], go to DONE.
//     - If the count reaches TIMEOUT-1 with no ack, go to ERR.
//     - If m_ack and timeout fall in the same cycle, m_ack wins.
//   - ERR: pulse s_err[g] for 1 cycle, m_cyc=0, go to DONE.
//   - DONE (1 cycle gap): all m_* outputs 0, ptr = (g+1) mod NUM_REQ, go to IDLE.
//     - This gap lets the requester drop stb, so a stale strobe is never re-granted.
// - Latency for an idle bus: request seen at edge n -> m_stb high n+1 -> m_ack n+2 -> s_ack pulse n+3.
//   - The s_ack pulse is registered.
// - s_dat_r holds its last captured value until the next read completes. It is not cleared on writes.
// - m_dat_w, m_adr and m_we are stable from ISSUE through WAIT.
// - A requester dropping s_cyc during ISSUE/WAIT does not abort the slave access.
//   - Its s_ack/s_err is still pulsed and may be ignored.
// - Only one s_ack/s_err bit is ever high, and only for the granted index.
// - Timeout counter: $clog2(TIMEOUT) bits, cleared on entering WAIT, saturates, never wraps.
// STRUCTURE
// - Package wb_arb_pkg:
//   - state enum {IDLE, ISSUE, WAIT, ERR, DONE}.
//   - WB_AW=32 and WB_DW=32 constants.
//   - function idx_width(NUM_REQ).
// - Sub-module rr_pick: combinational; inputs req vector and ptr; outputs grant index and valid.
//   - Reused by later arbiters.
// - FSM, counter and m_* registers live in wb_rr_arbiter.
// TESTING
// - Bench slave model: acks one cycle after stb and only for addr<255. Tristate resolved in the bench top.
// - Single write: req0 write adr=5 dat=0xA5A5 -> m_stb 1 cycle, s_ack[0] at n+3, memory[5]=0xA5A5.
// - Read back: req1 read adr=50 (preloaded 500) -> s_ack[1] pulse, s_dat_r=500 in the same cycle.
// - Contention: req0 and req1 both assert in the same cycle, ptr=0.
//   - Grant order 0,1,0,1 over 4 transactions.
//   - No requester waits more than one transaction.
// - Range error: req0 adr=100 with ADDR_LIMIT=64 -> s_err[0] at n+2, m_cyc never asserted.
// - Timeout: slave ack disabled -> s_err[g] after exactly TIMEOUT WAIT cycles.
//   - m_cyc drops and the next requester is granted after DONE.
// - Reset: rst_n low during WAIT -> all outputs 0 asynchronously. No pulse after release.
//   - First grant after reset goes to requester 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter family.
package wb_arb_pkg;

   localparam int unsigned WB_AW = 32;
   localparam int unsigned WB_DW = 32;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StErr,
      StDone
   } arb_state_e;

   function automatic int unsigned idx_width(input int unsigned num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   grant_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      cand    = '0;
      // Scan from the farthest offset back to ptr so the nearest requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[cand]) begin
            grant_o = cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_REQ requesters, with
// address range check and ack timeout.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_LIMIT = 64,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       s_cyc,
   input  logic [NUM_REQ-1:0]       s_stb,
   input  logic [NUM_REQ-1:0]       s_we,
   input  logic [NUM_REQ*WB_AW-1:0] s_adr,
   input  logic [NUM_REQ*WB_DW-1:0] s_dat_w,
   output logic [WB_DW-1:0]         s_dat_r,
   output logic [NUM_REQ-1:0]       s_ack,
   output logic [NUM_REQ-1:0]       s_err,
   output logic                     m_cyc,
   output logic                     m_stb,
   output logic                     m_we,
   output logic [WB_AW-1:0]         m_adr,
   output logic [WB_DW-1:0]         m_dat_w,
   output logic                     m_oe,
   input  logic [WB_DW-1:0]         m_dat_r,
   input  logic                     m_ack
);

   localparam int unsigned IdxW = idx_width(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   arb_state_e          state_q, state_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [IdxW-1:0]     gnt_q, gnt_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [WB_AW-1:0]    adr_q, adr_d;
   logic                we_q, we_d;
   logic [WB_DW-1:0]    dat_w_q, dat_w_d;
   logic [WB_DW-1:0]    dat_r_q, dat_r_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [NUM_REQ-1:0]  err_q, err_d;

   logic [NUM_REQ-1:0]  req;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_valid;
   logic [WB_AW-1:0]    pick_adr;
   logic                pick_oob;

   assign req = s_cyc & s_stb;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IdxW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (pick_idx),
      .valid_o (pick_valid)
   );

   assign pick_adr = s_adr[pick_idx*WB_AW +: WB_AW];
   assign pick_oob = (pick_adr >= WB_AW'(ADDR_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d = pick_oob ? StErr : StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            // A late ack still wins over a timeout in the same cycle.
            if (m_ack) begin
               state_d = StDone;
            end else if (cnt_q == CntLast) begin
               state_d = StErr;
            end
         end
         StErr:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      m_cyc   = 1'b0;
      m_stb   = 1'b0;
      m_we    = 1'b0;
      m_adr   = '0;
      m_dat_w = '0;
      if (state_q == StIssue || state_q == StWait) begin
         m_cyc   = 1'b1;
         m_stb   = (state_q == StIssue);
         m_we    = we_q;
         m_adr   = adr_q;
         m_dat_w = dat_w_q;
      end
   end

   assign m_oe    = m_cyc & m_we;
   assign s_ack   = ack_q;
   assign s_err   = err_q;
   assign s_dat_r = dat_r_q;

   always_comb begin
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      we_d    = we_q;
      dat_w_d = dat_w_q;
      dat_r_d = dat_r_q;
      ack_d   = '0;
      err_d   = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               gnt_d = pick_idx;
               if (!pick_oob) begin
                  adr_d   = pick_adr;
                  we_d    = s_we[pick_idx];
                  dat_w_d = s_dat_w[pick_idx*WB_DW +: WB_DW];
               end
            end
         end
         StIssue: cnt_d = '0;
         StWait: begin
            if (m_ack) begin
               ack_d[gnt_q] = 1'b1;
               if (!we_q) begin
                  dat_r_d = m_dat_r;
               end
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StErr: err_d[gnt_q] = 1'b1;
         StDone: ptr_d = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         dat_w_q <= '0;
         dat_r_q <= '0;
         ack_q   <= '0;
         err_q   <= '0;
      end else begin
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         dat_w_q <= dat_w_d;
         dat_r_q <= dat_r_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: slave model with resolved data bus and a
// scoreboard of expected ack/err pulses checked by a monitor.
module tb_wb_rr_arbiter;

   localparam int unsigned NR  = 2;
   localparam int unsigned LIM = 64;
   localparam int unsigned TO  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     s_cyc, s_stb, s_we, s_ack, s_err;
   logic [NR*32-1:0]  s_adr, s_dat_w;
   logic [31:0]       s_dat_r, m_adr, m_dat_w, m_dat_r;
   logic              m_cyc, m_stb, m_we, m_oe, m_ack;
   wire  [31:0]       wb_bus;

   always #5 clk = ~clk;

   wb_rr_arbiter #(
      .NUM_REQ    (NR),
      .ADDR_LIMIT (LIM),
      .TIMEOUT    (TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_cyc   (s_cyc),
      .s_stb   (s_stb),
      .s_we    (s_we),
      .s_adr   (s_adr),
      .s_dat_w (s_dat_w),
      .s_dat_r (s_dat_r),
      .s_ack   (s_ack),
      .s_err   (s_err),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_we    (m_we),
      .m_adr   (m_adr),
      .m_dat_w (m_dat_w),
      .m_oe    (m_oe),
      .m_dat_r (m_dat_r),
      .m_ack   (m_ack)
   );

   // Slave: acks one cycle after stb for addr < 255.
   logic [31:0] mem [256];
   logic        slv_ack_q;
   logic [31:0] slv_rd_q;
   bit          ack_en = 1'b1;
   bit          preload = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (preload) mem[50] <= 32'd500;
      if (!rst_n) begin
         slv_ack_q <= 1'b0;
         slv_rd_q  <= '0;
      end else begin
         slv_ack_q <= 1'b0;
         if (m_cyc && m_stb && ack_en && m_adr < 32'd255) begin
            slv_ack_q <= 1'b1;
            slv_rd_q  <= mem[m_adr[7:0]];
            if (m_we) mem[m_adr[7:0]] <= wb_bus;
         end
      end
   end

   assign wb_bus  = m_oe ? m_dat_w : (slv_ack_q ? slv_rd_q : 32'h0);
   assign m_dat_r = wb_bus;
   assign m_ack   = slv_ack_q;

   typedef struct {
      int          idx;
      bit          err;
      bit          rd;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [256];
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int i, input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, input bit tmo);
      exp_t e;
      e.idx = i;
      e.err = tmo || (adr >= LIM);
      e.rd  = !we;
      e.dat = ref_mem[adr[7:0]];
      if (we && !e.err) ref_mem[adr[7:0]] = dat;
      sb.push_back(e);
   endtask

   task automatic do_txn(input int i, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, output int lat, output int stb_n,
                         output int cyc_n);
      lat   = -1;
      stb_n = 0;
      cyc_n = 0;
      @(negedge clk);
      s_we[i]           = we;
      s_adr[i*32 +: 32]   = adr;
      s_dat_w[i*32 +: 32] = dat;
      s_cyc[i]          = 1'b1;
      s_stb[i]          = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (m_stb) stb_n++;
         if (m_cyc) cyc_n++;
         if (s_ack[i] || s_err[i]) begin
            lat = k;
            break;
         end
      end
      s_cyc[i] = 1'b0;
      s_stb[i] = 1'b0;
      tests++;
      assert (lat >= 0)
      else begin
         fails++;
         $error("FAIL txn_bound: requester %0d got no ack/err within 64 cycles", i);
      end
   endtask

   exp_t          mon_e;
   logic [NR-1:0] mon_oh;

   always @(negedge clk) begin
      if (rst_n && (s_ack != '0 || s_err != '0)) begin
         check("pulse_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e  = sb.pop_front();
            mon_oh = NR'(1) << mon_e.idx;
            check("s_ack_vec", 32'(s_ack), mon_e.err ? 32'd0 : 32'(mon_oh));
            check("s_err_vec", 32'(s_err), mon_e.err ? 32'(mon_oh) : 32'd0);
            if (mon_e.rd && !mon_e.err) check("s_dat_r", s_dat_r, mon_e.dat);
         end
      end
   end

   int lat, sn, cn, l1, s1, c1, l2, s2, c2;

   initial begin
      s_cyc = '0; s_stb = '0; s_we = '0; s_adr = '0; s_dat_w = '0;
      ref_mem[50] = 32'd500;
      repeat (3) @(negedge clk);
      check("rst_m_cyc", 32'(m_cyc), 32'd0);
      check("rst_m_stb", 32'(m_stb), 32'd0);
      check("rst_m_oe", 32'(m_oe), 32'd0);
      check("rst_s_ack", 32'(s_ack), 32'd0);
      check("rst_s_err", 32'(s_err), 32'd0);
      check("rst_s_dat_r", s_dat_r, 32'd0);
      preload = 1'b0;
      rst_n   = 1'b1;

      // Single write
      push_exp(0, 1'b1, 32'd5, 32'hA5A5, 1'b0);
      do_txn(0, 1'b1, 32'd5, 32'hA5A5, lat, sn, cn);
      check("wr_latency", 32'(lat), 32'd3);
      check("wr_stb_cycles", 32'(sn), 32'd1);
      check("wr_cyc_cycles", 32'(cn), 32'd2);
      check("wr_mem5", mem[5], 32'hA5A5);

      // Read preloaded word
      push_exp(1, 1'b0, 32'd50, 32'd0, 1'b0);
      do_txn(1, 1'b0, 32'd50, 32'd0, lat, sn, cn);
      check("rd_latency", 32'(lat), 32'd3);

      // Range error: slave never touched
      push_exp(0, 1'b1, 32'd100, 32'd7, 1'b0);
      do_txn(0, 1'b1, 32'd100, 32'd7, lat, sn, cn);
      check("oob_latency", 32'(lat), 32'd2);
      check("oob_cyc_cycles", 32'(cn), 32'd0);
      check("oob_stb_cycles", 32'(sn), 32'd0);

      // Timeout on req1, req0 queued behind it and served once ack is back
      ack_en = 1'b0;
      push_exp(1, 1'b0, 32'd20, 32'd0, 1'b1);
      push_exp(0, 1'b1, 32'd9, 32'h99, 1'b0);
      fork
         begin
            do_txn(1, 1'b0, 32'd20, 32'd0, l1, s1, c1);
            ack_en = 1'b1;
         end
         begin
            repeat (3) @(negedge clk);
            do_txn(0, 1'b1, 32'd9, 32'h99, l2, s2, c2);
         end
      join
      check("tmo_latency", 32'(l1), 32'(TO + 3));
      check("tmo_cyc_cycles", 32'(c1), 32'(TO + 1));
      check("tmo_stb_cycles", 32'(s1), 32'd1);
      check("tmo_next_grant_latency", 32'(l2), 32'd20);
      check("dat_r_held_over_write", s_dat_r, 32'd500);
      check("tmo_wr_mem9", mem[9], 32'h99);

      // Read back the first write through the bus
      push_exp(0, 1'b0, 32'd5, 32'd0, 1'b0);
      do_txn(0, 1'b0, 32'd5, 32'd0, lat, sn, cn);
      check("rdback_latency", 32'(lat), 32'd3);
      @(negedge clk);
      check("dat_r_hold", s_dat_r, 32'hA5A5);

      // Reset during WAIT
      ack_en = 1'b0;
      @(negedge clk);
      s_we[1] = 1'b0; s_adr[32 +: 32] = 32'd30; s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_in_wait", 32'(m_cyc), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_m_cyc", 32'(m_cyc), 32'd0);
      check("arst_m_stb", 32'(m_stb), 32'd0);
      check("arst_m_oe", 32'(m_oe), 32'd0);
      check("arst_m_adr", m_adr, 32'd0);
      check("arst_s_dat_r", s_dat_r, 32'd0);
      check("arst_s_pulses", 32'({s_ack, s_err}), 32'd0);
      s_cyc[1] = 1'b0; s_stb[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      ack_en = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_idle_cyc", 32'(m_cyc), 32'd0);
      check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

      // Contention from reset pointer: expect grants 0,1,0,1
      push_exp(0, 1'b1, 32'd10, 32'd1, 1'b0);
      push_exp(1, 1'b0, 32'd50, 32'd0, 1'b0);
      push_exp(0, 1'b1, 32'd11, 32'd2, 1'b0);
      push_exp(1, 1'b0, 32'd50, 32'd0, 1'b0);
      fork
         begin
            int a0, b0, c0, a1, b1, c1x;
            do_txn(0, 1'b1, 32'd10, 32'd1, a0, b0, c0);
            do_txn(0, 1'b1, 32'd11, 32'd2, a1, b1, c1x);
            check("cont_r0_first_lat", 32'(a0), 32'd3);
            check("cont_r0_second_lat", 32'(a1), 32'd7);
         end
         begin
            int a2, b2, c2x, a3, b3, c3;
            do_txn(1, 1'b0, 32'd50, 32'd0, a2, b2, c2x);
            do_txn(1, 1'b0, 32'd50, 32'd0, a3, b3, c3);
            check("cont_r1_first_lat", 32'(a2), 32'd7);
            check("cont_r1_second_lat", 32'(a3), 32'd7);
         end
      join
      repeat (2) @(negedge clk);
      check("cont_sb_drained", 32'(sb.size()), 32'd0);
      check("cont_mem10", mem[10], 32'd1);
      check("cont_mem11", mem[11], 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
